// File: rtl/conv3x3_ctrl_pkg.sv
// Shared widths, FSM encoding, window type and address helper for the 3x3 convolution sequencer.
package conv3x3_ctrl_pkg;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned PSUM_W      = 16;
   localparam int unsigned ACC_W       = 20;
   localparam int unsigned DIM_W       = 8;
   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned PE_LAT      = 1;
   localparam int unsigned KERNEL_TAPS = 9;
   localparam int unsigned WIN_W       = KERNEL_TAPS * DATA_W;
   localparam int unsigned PSUMS_W     = KERNEL_TAPS * PSUM_W;
   localparam int unsigned LAT_W       = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_FLT,
      ST_FETCH,
      ST_WAIT_PE,
      ST_REDUCE,
      ST_OUT,
      ST_DONE
   } state_e;

   // Index 0 is the most significant slot, so tap t = r*3+c lands at [71-8t -: 8].
   typedef logic [0:2][0:2][DATA_W-1:0] win_t;

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [DIM_W-1:0]  w,
                                                  input logic [DIM_W-1:0]  y,
                                                  input logic [DIM_W-1:0]  x,
                                                  input logic [1:0]        r,
                                                  input logic [1:0]        c);
      logic [31:0] row;
      logic [31:0] col;
      logic [31:0] a;
      row = 32'(y) + 32'(r);
      col = 32'(x) + 32'(c);
      a   = 32'(base) + row * 32'(w) + col;
      return ADDR_W'(a);
   endfunction

endpackage

// File: rtl/conv3x3_ctrl_psum_reduce9.sv
// Registered reduction of the nine signed PE partial sums into one output pixel.
module psum_reduce9
   import conv3x3_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [PSUMS_W-1:0] psum_i,
   output logic [ACC_W-1:0]   sum_o
);

   logic [0:KERNEL_TAPS-1][PSUM_W-1:0] taps;
   logic [ACC_W-1:0]                   sum_c;
   logic [ACC_W-1:0]                   sum_q;

   assign taps = psum_i;

   // Nine 16-bit products always fit in ACC_W, so wrap-free two's-complement add is exact.
   always_comb begin
      sum_c = '0;
      for (int unsigned t = 0; t < KERNEL_TAPS; t++) begin
         sum_c = sum_c + {{(ACC_W-PSUM_W){taps[t][PSUM_W-1]}}, taps[t]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (en_i) begin
         sum_q <= sum_c;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/conv3x3_ctrl.sv
// 3x3 convolution sequencer: filter load, windowed ifmap fetch, PE hand-off, reduction and output stream.
module conv3x3_ctrl
   import conv3x3_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DIM_W-1:0]   cfg_w,
   input  logic [DIM_W-1:0]   cfg_h,
   input  logic [ADDR_W-1:0]  cfg_base,
   output logic               busy,
   output logic               done,
   input  logic               flt_valid,
   input  logic [DATA_W-1:0]  flt_data,
   output logic               flt_ready,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [DATA_W-1:0]  mem_rd_data,
   output logic [WIN_W-1:0]   pe_ifmap,
   output logic [WIN_W-1:0]   pe_filter,
   input  logic [PSUMS_W-1:0] pe_psum,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_data,
   output logic               out_last
);

   state_e             state_q, state_d;
   logic [DIM_W-1:0]   w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0]  base_q, base_d, addr_q, addr_d;
   logic [1:0]         rr_q, rr_d, cc_q, cc_d;
   logic [3:0]         fcnt_q, fcnt_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               busy_q, busy_d, done_q, done_d, flt_ready_q, flt_ready_d;
   logic               rd_en_q, rd_en_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic               fetch_go_c, nfull_c, reduce_en_c, flt_beat_c;
   logic [DIM_W-1:0]   nx_c, ny_c;
   logic [1:0]         rr_n_c, cc_n_c;

   logic               cap_en_q;
   logic [1:0]         cap_row_q;
   logic [DATA_W-1:0]  col0_q, col1_q;
   win_t               win_q;
   logic [WIN_W-1:0]   filt_q;

   assign flt_beat_c = flt_valid && flt_ready_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         h_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         rr_q        <= '0;
         cc_q        <= '0;
         fcnt_q      <= '0;
         lat_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         flt_ready_q <= 1'b0;
         rd_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         h_q         <= h_d;
         x_q         <= x_d;
         y_q         <= y_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         rr_q        <= rr_d;
         cc_q        <= cc_d;
         fcnt_q      <= fcnt_d;
         lat_q       <= lat_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         flt_ready_q <= flt_ready_d;
         rd_en_q     <= rd_en_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      h_d         = h_q;
      x_d         = x_q;
      y_d         = y_q;
      base_d      = base_q;
      addr_d      = addr_q;
      rr_d        = rr_q;
      cc_d        = cc_q;
      fcnt_d      = fcnt_q;
      lat_d       = lat_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      flt_ready_d = flt_ready_q;
      rd_en_d     = 1'b0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      fetch_go_c  = 1'b0;
      nfull_c     = 1'b0;
      nx_c        = '0;
      ny_c        = '0;
      reduce_en_c = 1'b0;
      rr_n_c      = '0;
      cc_n_c      = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_w >= DIM_W'(3) && cfg_h >= DIM_W'(3)) begin
                  w_d         = cfg_w;
                  h_d         = cfg_h;
                  base_d      = cfg_base;
                  busy_d      = 1'b1;
                  flt_ready_d = 1'b1;
                  fcnt_d      = '0;
                  state_d     = ST_LOAD_FLT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_LOAD_FLT: begin
            if (flt_beat_c) begin
               fcnt_d = fcnt_q + 4'd1;
               if (fcnt_q == 4'd8) begin
                  flt_ready_d = 1'b0;
                  fetch_go_c  = 1'b1;
                  nfull_c     = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            // Read phase while rd_en is up; the cycle after the last read only captures data.
            if (rd_en_q) begin
               if (!(rr_q == 2'd2 && cc_q == 2'd2)) begin
                  rr_n_c  = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
                  cc_n_c  = (rr_q == 2'd2) ? cc_q + 2'd1 : cc_q;
                  rr_d    = rr_n_c;
                  cc_d    = cc_n_c;
                  rd_en_d = 1'b1;
                  addr_d  = pix_addr(base_q, w_q, y_q, x_q, rr_n_c, cc_n_c);
               end
            end else begin
               lat_d   = '0;
               state_d = ST_WAIT_PE;
            end
         end
         ST_WAIT_PE: begin
            if (lat_q == LAT_W'(PE_LAT - 1)) begin
               state_d = ST_REDUCE;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_REDUCE: begin
            reduce_en_c = 1'b1;
            out_valid_d = 1'b1;
            out_last_d  = (x_q == w_q - DIM_W'(3)) && (y_q == h_q - DIM_W'(3));
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (x_q < w_q - DIM_W'(3)) begin
                  fetch_go_c = 1'b1;
                  nx_c       = x_q + DIM_W'(1);
                  ny_c       = y_q;
               end else if (y_q < h_q - DIM_W'(3)) begin
                  fetch_go_c = 1'b1;
                  nfull_c    = 1'b1;
                  ny_c       = y_q + DIM_W'(1);
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A full fetch starts at column 0, a slide fetches only the new column 2.
      if (fetch_go_c) begin
         state_d = ST_FETCH;
         x_d     = nx_c;
         y_d     = ny_c;
         rr_d    = 2'd0;
         cc_d    = nfull_c ? 2'd0 : 2'd2;
         rd_en_d = 1'b1;
         addr_d  = pix_addr(base_q, w_q, ny_c, nx_c, 2'd0, nfull_c ? 2'd0 : 2'd2);
      end
   end

   // Read-data capture, column assembly and filter shift-in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_en_q  <= 1'b0;
         cap_row_q <= '0;
         col0_q    <= '0;
         col1_q    <= '0;
         win_q     <= '0;
         filt_q    <= '0;
      end else begin
         cap_en_q  <= rd_en_q;
         cap_row_q <= rr_q;
         if (flt_beat_c) begin
            filt_q <= {filt_q[WIN_W-DATA_W-1:0], flt_data};
         end
         if (cap_en_q) begin
            case (cap_row_q)
               2'd0: col0_q <= mem_rd_data;
               2'd1: col1_q <= mem_rd_data;
               default: begin
                  for (int r = 0; r < 3; r++) begin
                     win_q[r][0] <= win_q[r][1];
                     win_q[r][1] <= win_q[r][2];
                  end
                  win_q[0][2] <= col0_q;
                  win_q[1][2] <= col1_q;
                  win_q[2][2] <= mem_rd_data;
               end
            endcase
         end
      end
   end

   psum_reduce9 u_reduce (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (reduce_en_c),
      .psum_i (pe_psum),
      .sum_o  (out_data)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign flt_ready = flt_ready_q;
   assign mem_rd_en = rd_en_q;
   assign mem_addr  = addr_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign pe_ifmap  = win_q;
   assign pe_filter = filt_q;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
// Scoreboard bench for conv3x3_ctrl with byte SRAM and 1-cycle PE array models.
module tb_conv3x3_ctrl;
   import conv3x3_ctrl_pkg::*;

   logic               clk, rst_n, start;
   logic [DIM_W-1:0]   cfg_w, cfg_h;
   logic [ADDR_W-1:0]  cfg_base;
   logic               busy, done, flt_valid, flt_ready, mem_rd_en;
   logic [DATA_W-1:0]  flt_data, mem_rd_data;
   logic [ADDR_W-1:0]  mem_addr;
   logic [WIN_W-1:0]   pe_ifmap, pe_filter;
   logic [PSUMS_W-1:0] pe_psum;
   logic               out_valid, out_ready, out_last;
   logic [ACC_W-1:0]   out_data;

   conv3x3_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .cfg_base(cfg_base), .busy(busy), .done(done), .flt_valid(flt_valid),
      .flt_data(flt_data), .flt_ready(flt_ready), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .pe_ifmap(pe_ifmap),
      .pe_filter(pe_filter), .pe_psum(pe_psum), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

   // PE array: one registered signed product per tap.
   always @(posedge clk) begin : pe_model
      logic signed [15:0] pa, pb;
      for (int t = 0; t < 9; t++) begin
         pa = {{8{pe_ifmap[71-8*t]}}, pe_ifmap[71-8*t -: 8]};
         pb = {{8{pe_filter[71-8*t]}}, pe_filter[71-8*t -: 8]};
         pe_psum[143-16*t -: 16] <= pa * pb;
      end
   end

   typedef struct packed { logic last; logic [ACC_W-1:0] data; } exp_t;
   exp_t        exp_q[$];
   logic [15:0] addr_log[$];
   int          gaps[$];
   int n_vec = 0, n_err = 0;
   int rd_cnt = 0, done_cnt = 0, flt_rdy_cnt = 0, oval_cnt = 0, gap = 0;
   bit done_chk = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", nm, act, act, expv, expv);
      end
   endtask

   task automatic push_exp(input int d, input bit l);
      exp_t e;
      e.data = ACC_W'(d);
      e.last = l;
      exp_q.push_back(e);
   endtask

   // Monitor: pops the scoreboard on every accepted output beat.
   always @(negedge clk) begin
      exp_t e;
      if (mem_rd_en === 1'b1) begin rd_cnt++; addr_log.push_back(mem_addr); end
      if (done === 1'b1) done_cnt++;
      if (flt_ready === 1'b1) flt_rdy_cnt++;
      if (out_valid === 1'b1) oval_cnt++;
      if (done_chk) begin
         chk("done_after_last", 32'(done), 32'd1);
         done_chk = 0;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got data=%0d last=%0d, none expected", out_data, out_last);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_last", 32'(out_last), 32'(e.last));
         end
         if (out_last === 1'b1) done_chk = 1;
         gaps.push_back(gap);
         gap = 0;
      end else if (out_valid !== 1'b1) begin
         gap++;
      end
   end

   task automatic start_job(input logic [7:0] w, input logic [7:0] h, input logic [15:0] base);
      @(posedge clk); #1;
      start = 1'b1; cfg_w = w; cfg_h = h; cfg_base = base;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_filter(input logic [71:0] f);
      int to;
      for (int i = 0; i < 9; i++) begin
         flt_valid = 1'b1;
         flt_data  = f[71-8*i -: 8];
         to = 0;
         @(negedge clk);
         while (flt_ready !== 1'b1 && to < 50) begin @(negedge clk); to++; end
         if (flt_ready !== 1'b1) begin
            chk("flt_ready_timeout", 32'(flt_ready), 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      flt_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int to = 0;
      while (done_cnt == d0 && to < 400) begin @(negedge clk); to++; end
      repeat (3) @(negedge clk);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   task automatic first_out_latency(output int lat);
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         if (out_valid === 1'b1) break;
         lat++;
      end
   endtask

   task automatic run_test1(input string tag);
      int d0, r0, g0, lat;
      push_exp(54, 0); push_exp(63, 0); push_exp(90, 0); push_exp(99, 1);
      d0 = done_cnt; r0 = rd_cnt; g0 = gaps.size();
      start_job(8'd4, 8'd4, 16'h0000);
      load_filter(72'h01_01_01_01_01_01_01_01_01);
      first_out_latency(lat);
      chk({tag, "_full_latency"}, 32'(lat), 32'd12);
      wait_done(d0);
      chk({tag, "_reads"}, 32'(rd_cnt - r0), 32'd24);
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      if (gaps.size() >= g0 + 4) begin
         chk({tag, "_slide_gap"}, 32'(gaps[g0+1]), 32'd6);
         chk({tag, "_row_gap"}, 32'(gaps[g0+2]), 32'd12);
         chk({tag, "_slide_gap2"}, 32'(gaps[g0+3]), 32'd6);
      end else begin
         chk({tag, "_accept_count"}, 32'(gaps.size() - g0), 32'd4);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end

   initial begin : stim
      int d0, r0, f0, o0, al0, lat;
      logic [15:0] win4 [0:8];
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      rst_n = 1'b0; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_base = '0;
      flt_valid = 1'b0; flt_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_flt_ready", 32'(flt_ready), 32'd0);
      chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_pe_ifmap", 32'(|pe_ifmap), 32'd0);
      chk("rst_pe_filter", 32'(|pe_filter), 32'd0);
      rst_n = 1'b1;

      // 4x4 image 1..16, all-ones filter, no back-pressure
      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
      run_test1("t1");

      // same job with a 5-cycle stall on the first output
      out_ready = 1'b0;
      push_exp(54, 0); push_exp(63, 0); push_exp(90, 0); push_exp(99, 1);
      d0 = done_cnt; r0 = rd_cnt;
      start_job(8'd4, 8'd4, 16'h0000);
      load_filter(72'h01_01_01_01_01_01_01_01_01);
      first_out_latency(lat);
      chk("t2_full_latency", 32'(lat), 32'd12);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("t2_stall_data", 32'(out_data), 32'd54);
         chk("t2_stall_no_read", 32'(mem_rd_en), 32'd0);
         chk("t2_stall_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(d0);
      chk("t2_reads", 32'(rd_cnt - r0), 32'd24);
      chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

      // 3x3 image of -128 with filter of -128: largest positive sum
      for (int i = 0; i < 9; i++) mem[16'h200 + i] = 8'h80;
      push_exp(147456, 1);
      d0 = done_cnt; r0 = rd_cnt;
      start_job(8'd3, 8'd3, 16'h0200);
      load_filter(72'h80_80_80_80_80_80_80_80_80);
      wait_done(d0);
      chk("t3_reads", 32'(rd_cnt - r0), 32'd9);
      chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

      // undersized job: immediate done, nothing else
      d0 = done_cnt; r0 = rd_cnt; f0 = flt_rdy_cnt; o0 = oval_cnt;
      @(posedge clk); #1;
      start = 1'b1; cfg_w = 8'd2; cfg_h = 8'd5; cfg_base = 16'h0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("t4_done_pulse", 32'(done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t4_done_one_cycle", 32'(done), 32'd0);
      repeat (5) @(negedge clk);
      chk("t4_no_flt_ready", 32'(flt_rdy_cnt - f0), 32'd0);
      chk("t4_no_reads", 32'(rd_cnt - r0), 32'd0);
      chk("t4_no_out_valid", 32'(oval_cnt - o0), 32'd0);
      chk("t4_done_count", 32'(done_cnt - d0), 32'd1);

      // 5x4 at 0x100, filter k00=1 k22=2: out = p(y,x) + 2*p(y+2,x+2)
      for (int i = 0; i < 20; i++) mem[16'h100 + i] = 8'(i);
      push_exp(24, 0); push_exp(27, 0); push_exp(30, 0);
      push_exp(39, 0); push_exp(42, 0); push_exp(45, 1);
      d0 = done_cnt; r0 = rd_cnt; al0 = addr_log.size();
      start_job(8'd5, 8'd4, 16'h0100);
      load_filter(72'h01_00_00_00_00_00_00_00_02);
      wait_done(d0);
      chk("t5_reads", 32'(rd_cnt - r0), 32'd30);
      chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
      win4 = '{16'h105, 16'h10A, 16'h10F, 16'h106, 16'h10B, 16'h110, 16'h107, 16'h10C, 16'h111};
      if (addr_log.size() >= al0 + 30) begin
         chk("t5_w2_addr0", 32'(addr_log[al0+9]),  32'h103);
         chk("t5_w2_addr1", 32'(addr_log[al0+10]), 32'h108);
         chk("t5_w2_addr2", 32'(addr_log[al0+11]), 32'h10D);
         for (int k = 0; k < 9; k++) chk("t5_w4_addr", 32'(addr_log[al0+15+k]), 32'(win4[k]));
      end else begin
         chk("t5_addr_log_len", 32'(addr_log.size() - al0), 32'd30);
      end

      // reset mid-FETCH abandons the job, then a clean rerun
      d0 = done_cnt;
      start_job(8'd4, 8'd4, 16'h0000);
      load_filter(72'h01_01_01_01_01_01_01_01_01);
      @(negedge clk);
      chk("t6_in_fetch", 32'(mem_rd_en), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      repeat (30) @(negedge clk);
      chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
      run_test1("t6_rerun");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
